// File: rtl/vred_unit.sv
// vred_unit: sequential vector reduction (sum / signed min / signed max).
// One request is captured in IDLE, one element is folded into the
// accumulator per cycle in RUN, and the result is held in DONE until it
// is accepted.
module vred_unit #(
  parameter int VLEN = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VLEN-1:0] vec_in,
  input  logic [VLEN-1:0] seed_in,
  input  logic [7:0]      sew,
  input  logic [1:0]      red_op,
  input  logic [7:0]      vl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] result,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_MIN = 2'b01;
  localparam logic [1:0] OP_MAX = 2'b10;

  // Low-SEW-bit mask; zero for an unsupported width.
  function automatic logic [VLEN-1:0] sew_mask(input logic [7:0] s);
    logic [VLEN-1:0] m;
    case (s)
      8'd8:    m = {{(VLEN-8){1'b0}}, {8{1'b1}}};
      8'd16:   m = {{(VLEN-16){1'b0}}, {16{1'b1}}};
      8'd32:   m = {{(VLEN-32){1'b0}}, {32{1'b1}}};
      8'd64:   m = {{(VLEN-64){1'b0}}, {64{1'b1}}};
      8'd128:  m = {VLEN{1'b1}};
      default: m = {VLEN{1'b0}};
    endcase
    return m;
  endfunction

  // Number of elements that fit in the register for a given width.
  function automatic logic [7:0] elem_cap(input logic [7:0] s);
    logic [7:0] c;
    case (s)
      8'd8:    c = 8'(VLEN / 8);
      8'd16:   c = 8'(VLEN / 16);
      8'd32:   c = 8'(VLEN / 32);
      8'd64:   c = 8'(VLEN / 64);
      8'd128:  c = 8'(VLEN / 128);
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  // True for a supported element width.
  function automatic logic sew_ok(input logic [7:0] s);
    logic ok;
    case (s)
      8'd8, 8'd16, 8'd32, 8'd64, 8'd128: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t          state_q, state_d;
  logic [VLEN-1:0] vec_q, vec_d;
  logic [VLEN-1:0] acc_q, acc_d;
  logic [7:0]      sew_q, sew_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      count_q, count_d;
  logic [7:0]      n_q, n_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;

  logic [15:0]     shamt_s;
  logic [VLEN-1:0] mask_s;
  logic [VLEN-1:0] sign_s;
  logic [VLEN-1:0] elem_s;
  logic [VLEN-1:0] sum_s;
  logic            elem_lt_s;
  logic            elem_gt_s;
  logic [VLEN-1:0] comb_s;
  logic            cap_bad_s;
  logic [7:0]      cap_n_s;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign err       = err_q;

  // Element selection and fold of element[count] into the accumulator.
  // Signed order is obtained by flipping the SEW sign bit and comparing
  // unsigned, which keeps one comparator for every width.
  always_comb begin
    shamt_s   = {8'd0, count_q} * {8'd0, sew_q};
    mask_s    = sew_mask(sew_q);
    sign_s    = mask_s ^ (mask_s >> 1);
    elem_s    = (vec_q >> shamt_s) & mask_s;
    sum_s     = (acc_q + elem_s) & mask_s;
    elem_lt_s = (elem_s ^ sign_s) < (acc_q ^ sign_s);
    elem_gt_s = (elem_s ^ sign_s) > (acc_q ^ sign_s);
    case (op_q)
      OP_SUM:  comb_s = sum_s;
      OP_MIN:  comb_s = elem_lt_s ? elem_s : acc_q;
      OP_MAX:  comb_s = elem_gt_s ? elem_s : acc_q;
      default: comb_s = acc_q;
    endcase
  end

  // Request decode at capture: error flag and clamped element count.
  always_comb begin
    cap_bad_s = !sew_ok(sew) || (red_op == 2'b11);
    if (vl < elem_cap(sew)) begin
      cap_n_s = vl;
    end else begin
      cap_n_s = elem_cap(sew);
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    acc_d       = acc_q;
    sew_d       = sew_q;
    op_d        = op_q;
    count_d     = count_q;
    n_d         = n_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (in_valid) begin
          vec_d   = vec_in;
          sew_d   = sew;
          op_d    = red_op;
          err_d   = cap_bad_s;
          acc_d   = cap_bad_s ? {VLEN{1'b0}} : (seed_in & sew_mask(sew));
          count_d = 8'd0;
          n_d     = cap_n_s;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (err_q || (n_q == 8'd0)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          acc_d   = comb_s;
          count_d = count_q + 8'd1;
          if (count_q == (n_q - 8'd1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= {VLEN{1'b0}};
      acc_q       <= {VLEN{1'b0}};
      sew_q       <= 8'd0;
      op_q        <= 2'b00;
      count_q     <= 8'd0;
      n_q         <= 8'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      acc_q       <= acc_d;
      sew_q       <= sew_d;
      op_q        <= op_d;
      count_q     <= count_d;
      n_q         <= n_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_vred_unit.sv
// Scoreboard bench for vred_unit: the driver pushes expected results,
// a negedge monitor compares whenever out_valid is high.
module tb_vred_unit;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] vec_in;
  logic [127:0] seed_in;
  logic [7:0]   sew;
  logic [1:0]   red_op;
  logic [7:0]   vl;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         err;

  typedef struct {
    logic [127:0] res;
    logic         er;
    int           lat;
    int           cap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 0;
  bit   expect_idle = 0;

  vred_unit #(.VLEN(128)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .vec_in(vec_in), .seed_in(seed_in), .sew(sew), .red_op(red_op), .vl(vl),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every cycle the DUT presents a result.
  always @(negedge clk) begin
    if (expect_idle) begin
      chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
      chk("b2b_out_valid", {127'd0, out_valid}, 128'd0);
      expect_idle = 0;
    end
    if (out_valid) begin
      chk("excl_in_ready", {127'd0, in_ready}, 128'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got result %h err %b expected none", result, err);
      end else begin
        chk("result", result, q[0].res);
        chk("err", {127'd0, err}, {127'd0, q[0].er});
        if (!seen) begin
          chk("latency", 128'(cyc - q[0].cap), 128'(q[0].lat));
          seen = 1;
        end
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
          expect_idle = 1;
        end
      end
    end
  end

  task automatic issue(input logic [127:0] v, input logic [127:0] s, input logic [7:0] w,
                       input logic [1:0] op, input logic [7:0] l,
                       input logic [127:0] er, input logic ee, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready %b expected 1", in_ready);
    end
    vec_in = v; seed_in = s; sew = w; red_op = op; vl = l; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.res = er; e.er = ee; e.lat = lat; e.cap = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending %0d expected 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  localparam logic [127:0] V_INC  = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] V_W32  = 128'h00000000_7FFFFFFF_FFFFFFFE_00000005;
  localparam logic [127:0] V_FF   = {16{8'hFF}};
  localparam logic [127:0] V_W64  = {64'h1, 64'h8000000000000000};
  localparam logic [127:0] V_W16  = {80'h0, 16'h0003, 16'h0002, 16'hFFFF};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    vec_in = 128'd0; seed_in = 128'd0; sew = 8'd8; red_op = 2'b00; vl = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_result", result, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {127'd0, in_ready}, 128'd1);

    // Directed vectors.
    issue(V_INC, 128'd0, 8'd8, 2'b00, 8'd16, 128'h88, 1'b0, 16, 1'b1); drain();
    issue(V_W32, 128'd3, 8'd32, 2'b01, 8'd4, 128'hFFFFFFFE, 1'b0, 4, 1'b1); drain();
    issue(V_W32, 128'd3, 8'd32, 2'b10, 8'd4, 128'h7FFFFFFF, 1'b0, 4, 1'b1); drain();
    issue(V_FF, 128'd0, 8'd8, 2'b00, 8'd20, 128'hF0, 1'b0, 16, 1'b1); drain();
    issue(V_INC, {112'h1, 16'h1234}, 8'd16, 2'b10, 8'd0, 128'h1234, 1'b0, 1, 1'b1); drain();
    issue(V_INC, 128'd7, 8'd24, 2'b00, 8'd4, 128'd0, 1'b1, 1, 1'b1); drain();
    issue(V_INC, 128'd7, 8'd8, 2'b11, 8'd4, 128'd0, 1'b1, 1, 1'b1); drain();
    issue(128'h10, 128'd5, 8'd128, 2'b00, 8'd1, 128'h15, 1'b0, 1, 1'b1); drain();
    issue(V_W64, 128'd0, 8'd64, 2'b01, 8'd2, 128'h8000000000000000, 1'b0, 2, 1'b1); drain();
    issue(V_W16, 128'd1, 8'd16, 2'b00, 8'd3, 128'h5, 1'b0, 3, 1'b1); drain();

    // Back-to-back: second request accepted right after DONE->IDLE.
    issue(V_INC, 128'd0, 8'd8, 2'b00, 8'd5, 128'hF, 1'b0, 5, 1'b1);
    issue(V_INC, 128'd0, 8'd8, 2'b10, 8'd16, 128'h10, 1'b0, 16, 1'b1);
    drain();

    // Output stall with an ignored request during DONE.
    @(posedge clk); #1; out_ready = 1'b0;
    issue(V_INC, 128'd0, 8'd8, 2'b00, 8'd5, 128'hF, 1'b0, 5, 1'b1);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("stall_valid", {127'd0, out_valid}, 128'd1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
      if (k == 2) begin
        vec_in = {16{8'h77}}; sew = 8'd8; red_op = 2'b00; vl = 8'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1; out_ready = 1'b1;
    drain();
    repeat (20) @(negedge clk);

    // Reset in the middle of RUN at count=3.
    issue(V_INC, 128'd0, 8'd8, 2'b00, 8'd16, 128'd0, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_result", result, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    repeat (25) @(negedge clk);
    issue(V_INC, 128'd2, 8'd8, 2'b00, 8'd3, 128'h8, 1'b0, 3, 1'b1); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
